// File: rtl/pcm_sample_unpacker.sv
// Unpacks PCM bytes from a show-ahead FIFO into volume-scaled signed 16-bit left/right samples.
// Latency: outputs update N+2 clocks after the fetching next_sample tick (N = 1, 2 or 4 bytes per frame).
// Backpressure: pops only while the FIFO is non-empty; an empty FIFO mid-frame aborts it with an underrun pulse.
module pcm_sample_unpacker #(
    parameter int RATE_FULL = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        next_sample,
    input  logic [7:0]  sample_rate,
    input  logic        mode_stereo,
    input  logic        mode_16bit,
    input  logic [3:0]  volume,
    input  logic [7:0]  fifo_rddata,
    input  logic        fifo_empty,
    output logic        fifo_read,
    output logic [15:0] left_audio,
    output logic [15:0] right_audio,
    output logic        underrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    localparam logic [7:0] RATE_CAP = 8'(RATE_FULL);

    state_t             state;
    state_t             state_nxt;
    logic [6:0]         phase;
    logic [7:0]         rate_eff;
    logic [7:0]         rate_sum;
    logic               fetch_req;
    logic               pending;
    logic               start_frame;
    logic               stereo_q;
    logic               wide_q;
    logic [1:0]         byte_idx;
    logic [1:0]         byte_last;
    logic [3:0][7:0]    frame_bytes;
    logic [15:0]        samp_l;
    logic [15:0]        samp_r;
    logic [7:0]         gain;
    logic signed [23:0] prod_l;
    logic signed [23:0] prod_r;

    function automatic logic [7:0] gain_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    gain_lut = 8'd0;
            4'd1:    gain_lut = 8'd1;
            4'd2:    gain_lut = 8'd2;
            4'd3:    gain_lut = 8'd4;
            4'd4:    gain_lut = 8'd6;
            4'd5:    gain_lut = 8'd8;
            4'd6:    gain_lut = 8'd11;
            4'd7:    gain_lut = 8'd16;
            4'd8:    gain_lut = 8'd22;
            4'd9:    gain_lut = 8'd32;
            4'd10:   gain_lut = 8'd45;
            4'd11:   gain_lut = 8'd64;
            4'd12:   gain_lut = 8'd76;
            4'd13:   gain_lut = 8'd90;
            4'd14:   gain_lut = 8'd107;
            default: gain_lut = 8'd128;
        endcase
    endfunction

    // Clamp the rate and add it to the 7-bit phase; bit 7 of the sum is the fetch request
    always_comb begin
        rate_eff = (sample_rate >= RATE_CAP) ? RATE_CAP : sample_rate;
        rate_sum = {1'b0, phase} + rate_eff;
    end

    // Phase accumulator advances only on ticks; the request is registered for the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= '0;
            fetch_req <= 1'b0;
        end else begin
            fetch_req <= next_sample & rate_sum[7];
            if (next_sample) begin
                phase <= rate_sum[6:0];
            end
        end
    end

    // One-deep request queue: starting a frame consumes it, extra requests collapse into it
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (start_frame) begin
            pending <= 1'b0;
        end else if (fetch_req && state != S_IDLE) begin
            pending <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; a queued request starts the next frame straight out of APPLY
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending || fetch_req) begin
                    state_nxt   = S_FETCH;
                    start_frame = 1'b1;
                end
            end
            S_FETCH: begin
                if (fifo_empty) begin
                    state_nxt = S_IDLE;
                end else if (byte_idx == byte_last) begin
                    state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                if (pending || fetch_req) begin
                    state_nxt   = S_FETCH;
                    start_frame = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; reset gates the pop in the same cycle it is asserted
    always_comb begin
        fifo_read = 1'b0;
        underrun  = 1'b0;
        if (state == S_FETCH && !rst) begin
            fifo_read = !fifo_empty;
            underrun  = fifo_empty;
        end
    end

    // Latch the frame format at start and collect bytes in arrival order
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx    <= '0;
            stereo_q    <= 1'b0;
            wide_q      <= 1'b0;
            frame_bytes <= '0;
        end else if (start_frame) begin
            byte_idx <= '0;
            stereo_q <= mode_stereo;
            wide_q   <= mode_16bit;
        end else if (fifo_read) begin
            frame_bytes[byte_idx] <= fifo_rddata;
            byte_idx              <= byte_idx + 2'd1;
        end
    end

    // Last byte index of the frame: 0 for 8-bit mono, 1 for 8-bit stereo or 16-bit mono, 3 for 16-bit stereo
    assign byte_last = {wide_q & stereo_q, wide_q | stereo_q};

    // Form signed samples; 8-bit values sit in the upper byte, mono copies left to right
    always_comb begin
        if (wide_q) begin
            samp_l = {frame_bytes[1], frame_bytes[0]};
        end else begin
            samp_l = {frame_bytes[0], 8'h00};
        end
        if (!stereo_q) begin
            samp_r = samp_l;
        end else if (wide_q) begin
            samp_r = {frame_bytes[3], frame_bytes[2]};
        end else begin
            samp_r = {frame_bytes[1], 8'h00};
        end
    end

    // Volume scaling: gain is at most 128, so the shifted product always fits 16 bits
    always_comb begin
        gain   = gain_lut(volume);
        prod_l = $signed({{8{samp_l[15]}}, samp_l}) * $signed({16'd0, gain});
        prod_r = $signed({{8{samp_r[15]}}, samp_r}) * $signed({16'd0, gain});
    end

    // Both channels load together at the end of APPLY; aborted frames never reach here
    always_ff @(posedge clk) begin
        if (rst) begin
            left_audio  <= '0;
            right_audio <= '0;
        end else if (state == S_APPLY) begin
            left_audio  <= 16'(prod_l >>> 7);
            right_audio <= 16'(prod_r >>> 7);
        end
    end

endmodule

// File: tb/tb_pcm_sample_unpacker.sv
// Bench for pcm_sample_unpacker: byte FIFO model plus a frame-level reference for pacing, decode and gain.
// Latency: outputs are checked to hold at tick+N+1 and to update at tick+N+2.
// Backpressure: the bench FIFO pops on fifo_read and flags any pop while empty.
module tb_pcm_sample_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        next_sample;
    logic [7:0]  sample_rate;
    logic        mode_stereo;
    logic        mode_16bit;
    logic [3:0]  volume;
    logic [7:0]  fifo_rddata;
    logic        fifo_empty;
    logic        fifo_read;
    logic [15:0] left_audio;
    logic [15:0] right_audio;
    logic        underrun;

    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    int          ur_count = 0;
    int          m_phase = 0;
    logic [15:0] m_left = 16'h0;
    logic [15:0] m_right = 16'h0;
    logic [7:0]  fifo_q[$];
    int          gain_tbl[16] = '{0, 1, 2, 4, 6, 8, 11, 16, 22, 32, 45, 64, 76, 90, 107, 128};

    pcm_sample_unpacker #(.RATE_FULL(128)) dut (
        .clk         (clk),
        .rst         (rst),
        .next_sample (next_sample),
        .sample_rate (sample_rate),
        .mode_stereo (mode_stereo),
        .mode_16bit  (mode_16bit),
        .volume      (volume),
        .fifo_rddata (fifo_rddata),
        .fifo_empty  (fifo_empty),
        .fifo_read   (fifo_read),
        .left_audio  (left_audio),
        .right_audio (right_audio),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fifo_sync();
        fifo_empty  = (fifo_q.size() == 0);
        fifo_rddata = fifo_empty ? 8'($urandom) : fifo_q[0];
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_sync();
    endtask

    task automatic fill();
        while (fifo_q.size() < 4) push_byte(8'($urandom));
    endtask

    task automatic clear_fifo();
        fifo_q.delete();
        fifo_sync();
    endtask

    // One clock: observe at the falling edge, then update the FIFO just after the rising edge
    task automatic run_cycle();
        logic rd;
        @(negedge clk);
        rd = fifo_read;
        check_val("pop_while_empty", 16'(rd & fifo_empty), 16'd0);
        if (underrun) ur_count++;
        @(posedge clk);
        #1;
        if (rd) begin
            pops++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        fifo_sync();
    endtask

    // Rate pacing at frame level: fetch whenever the running phase crosses 128
    function automatic bit model_rate_step();
        int r;
        int sum;
        r = (sample_rate >= 8'd128) ? 128 : int'(sample_rate);
        sum = m_phase + r;
        m_phase = sum % 128;
        return sum >= 128;
    endfunction

    function automatic int sext(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    // Frame decode from bytes b0..b3 (b0 in bits 7:0) and gain index
    function automatic logic [31:0] model_decode(input bit st, input bit w, input logic [31:0] f,
                                                 input logic [3:0] vol);
        int l;
        int r;
        if (w) begin
            l = sext(int'(f[15:0]), 16);
            r = sext(int'(f[31:16]), 16);
        end else begin
            l = sext(int'(f[7:0]), 8) * 256;
            r = sext(int'(f[15:8]), 8) * 256;
        end
        if (!st) r = l;
        l = (l * gain_tbl[vol]) >>> 7;
        r = (r * gain_tbl[vol]) >>> 7;
        return {16'(l), 16'(r)};
    endfunction

    // Issue one tick and check pacing, pop count, latency and decoded samples
    task automatic frame_tick(input bit scramble);
        bit          fired;
        bit          st;
        bit          w;
        int          n;
        int          p0;
        logic [31:0] frame;
        logic [31:0] exp;
        st = mode_stereo;
        w  = mode_16bit;
        n  = (st && w) ? 4 : ((st || w) ? 2 : 1);
        frame = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < fifo_q.size()) frame[8*k +: 8] = fifo_q[k];
        end
        p0 = pops;
        fired = model_rate_step();
        next_sample = 1'b1;
        run_cycle();
        next_sample = 1'b0;
        if (fired) begin
            run_cycle();
            if (scramble) begin
                mode_stereo = 1'($urandom);
                mode_16bit  = 1'($urandom);
                volume      = 4'($urandom);
            end
            for (int i = 1; i < n + 1; i++) run_cycle();
            check_val("hold_left", left_audio, m_left);
            check_val("hold_right", right_audio, m_right);
            exp = model_decode(st, w, frame, volume);
            run_cycle();
            m_left  = exp[31:16];
            m_right = exp[15:0];
            check_val("left", left_audio, m_left);
            check_val("right", right_audio, m_right);
            check_val("frame_pops", 16'(pops - p0), 16'(n));
            for (int i = n + 3; i < 9; i++) run_cycle();
        end else begin
            for (int i = 0; i < 8; i++) run_cycle();
            check_val("idle_pops", 16'(pops - p0), 16'd0);
            check_val("idle_left", left_audio, m_left);
            check_val("idle_right", right_audio, m_right);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int u0;
        rst         = 1'b1;
        next_sample = 1'b0;
        sample_rate = 8'd128;
        mode_stereo = 1'b0;
        mode_16bit  = 1'b0;
        volume      = 4'd15;
        fifo_sync();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_read", 16'(fifo_read), 16'd0);
        check_val("rst_underrun", 16'(underrun), 16'd0);
        check_val("rst_left", left_audio, 16'h0000);
        check_val("rst_right", right_audio, 16'h0000);

        // 8-bit mono at full rate
        push_byte(8'h40);
        push_byte(8'hC0);
        frame_tick(1'b0);
        check_val("m8_l1", left_audio, 16'h4000);
        check_val("m8_r1", right_audio, 16'h4000);
        frame_tick(1'b0);
        check_val("m8_l2", left_audio, 16'hC000);
        check_val("m8_r2", right_audio, 16'hC000);

        // 16-bit stereo, full and reduced volume
        mode_stereo = 1'b1;
        mode_16bit  = 1'b1;
        clear_fifo();
        push_byte(8'h34); push_byte(8'h12); push_byte(8'h78); push_byte(8'h56);
        frame_tick(1'b0);
        check_val("s16_l1", left_audio, 16'h1234);
        check_val("s16_r1", right_audio, 16'h5678);
        volume = 4'd11;
        push_byte(8'h00); push_byte(8'h80); push_byte(8'hFF); push_byte(8'h7F);
        frame_tick(1'b0);
        check_val("s16_l2", left_audio, 16'hC000);
        check_val("s16_r2", right_audio, 16'h3FFF);

        // Quarter rate: a frame on every fourth tick
        mode_16bit  = 1'b0;
        sample_rate = 8'd32;
        volume      = 4'd13;
        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            int pt;
            pt = pops;
            fill();
            frame_tick(1'b0);
            check_val("r32_tick_pops", 16'(pops - pt), (i % 4 == 3) ? 16'd2 : 16'd0);
        end
        check_val("r32_total_pops", 16'(pops - p0), 16'd8);

        // Rates above full behave as full; zero rate never fetches
        sample_rate = 8'd200;
        p0 = pops;
        for (int i = 0; i < 4; i++) begin
            fill();
            frame_tick(1'b0);
        end
        check_val("r200_pops", 16'(pops - p0), 16'd8);
        sample_rate = 8'd0;
        p0 = pops;
        for (int i = 0; i < 4; i++) begin
            fill();
            frame_tick(1'b0);
        end
        check_val("r0_pops", 16'(pops - p0), 16'd0);

        // Underrun: 16-bit stereo frame with only three bytes available
        sample_rate = 8'd128;
        mode_stereo = 1'b1;
        mode_16bit  = 1'b1;
        volume      = 4'd15;
        clear_fifo();
        push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
        p0 = pops;
        u0 = ur_count;
        void'(model_rate_step());
        next_sample = 1'b1;
        run_cycle();
        next_sample = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle();
        check_val("ur_early", 16'(ur_count - u0), 16'd0);
        run_cycle();
        check_val("ur_pulse", 16'(ur_count - u0), 16'd1);
        for (int i = 0; i < 5; i++) run_cycle();
        check_val("ur_single", 16'(ur_count - u0), 16'd1);
        check_val("ur_pops", 16'(pops - p0), 16'd3);
        check_val("ur_left_hold", left_audio, m_left);
        check_val("ur_right_hold", right_audio, m_right);
        push_byte(8'h01); push_byte(8'h23); push_byte(8'h45); push_byte(8'h67);
        frame_tick(1'b0);
        check_val("post_ur_left", left_audio, 16'h2301);
        check_val("post_ur_right", right_audio, 16'h6745);

        // Pending: second tick during a frame queues, third tick is dropped
        clear_fifo();
        for (int k = 1; k <= 8; k++) push_byte(8'(k * 8'h11));
        p0 = pops;
        next_sample = 1'b1; run_cycle(); next_sample = 1'b0;
        run_cycle();
        next_sample = 1'b1; run_cycle(); next_sample = 1'b0;
        run_cycle();
        next_sample = 1'b1; run_cycle(); next_sample = 1'b0;
        run_cycle();
        check_val("pend_l0", left_audio, m_left);
        run_cycle();
        check_val("pend_l1", left_audio, 16'h2211);
        check_val("pend_r1", right_audio, 16'h4433);
        for (int i = 0; i < 4; i++) run_cycle();
        check_val("pend_l1_hold", left_audio, 16'h2211);
        run_cycle();
        check_val("pend_l2", left_audio, 16'h6655);
        check_val("pend_r2", right_audio, 16'h8877);
        for (int i = 0; i < 12; i++) run_cycle();
        check_val("pend_total_pops", 16'(pops - p0), 16'd8);
        m_left  = 16'h6655;
        m_right = 16'h8877;

        // Reset in the middle of a 16-bit stereo fetch
        push_byte(8'h10); push_byte(8'h20); push_byte(8'h30); push_byte(8'h40);
        next_sample = 1'b1; run_cycle(); next_sample = 1'b0;
        run_cycle();
        run_cycle();
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_read", 16'(fifo_read), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("midrst_left", left_audio, 16'h0000);
        check_val("midrst_right", right_audio, 16'h0000);
        check_val("midrst_read_after", 16'(fifo_read), 16'd0);
        p0 = pops;
        for (int i = 0; i < 10; i++) run_cycle();
        check_val("midrst_no_resume", 16'(pops - p0), 16'd0);
        clear_fifo();
        m_phase = 0;
        m_left  = 16'h0;
        m_right = 16'h0;

        // Randomized rates, formats, volumes and data, with mid-frame input changes
        for (int t = 0; t < 40; t++) begin
            sample_rate = 8'($urandom_range(0, 255));
            if (t % 5 == 0) sample_rate = 8'd128;
            mode_stereo = 1'($urandom);
            mode_16bit  = 1'($urandom);
            volume      = 4'($urandom);
            fill();
            frame_tick(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
